update_readback: RTL

- Read-side counterpart of the update write-address counter.
- Walks a contiguous, wrapping range of rule-RAM addresses and issues one read per cycle. It absorbs the fixed RAM read latency and delivers words on a valid/ready stream with a last marker.
- Sits beside the update logic. Used for table readback, scrubbing and debug dump of CAM entries.

---
 rtl/update_pkg.sv | 24 ++
 rtl/readback_fifo.sv | 76 +++++++
 rtl/update_readback.sv | 127 ++++++++++++
 3 files changed

// File: rtl/update_pkg.sv
// update_pkg
//   Shared definitions for the update-side readback logic.
//   - rb_state_t : readback FSM states (IDLE, READ, DRAIN, DONE)
//   - rb_depth   : FIFO depth, which also bounds in-flight reads plus buffered words
//   - rb_cnt_w   : width of the word counters; one extra bit so that a full
//                  2^ADDR_W scan length can be represented
package update_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } rb_state_t;

  function automatic int rb_depth(input int rd_lat);
    return rd_lat + 2;
  endfunction

  function automatic int rb_cnt_w(input int addr_w);
    return addr_w + 1;
  endfunction

endpackage

// File: rtl/readback_fifo.sv
// readback_fifo
//   Synchronous FIFO whose head word is held in output registers, so dout and
//   valid come straight from flops. A push into an empty FIFO is visible on
//   dout/valid in the following cycle. Simultaneous push and pop keeps count.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   push, din  : write strobe and word (ignored when full without a pop)
//   pop        : consume the head word (ignored when empty)
//   dout       : head word, held stable until popped
//   valid      : head word present
//   count      : number of stored words, including the head
module readback_fifo #(
  parameter  int WIDTH = 33,
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_ptr_nx;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop    = pop && (count != '0);
  assign do_push   = push && ((count != CNT_W'(DEPTH)) || do_pop);
  assign rd_ptr_nx = ptr_inc(rd_ptr);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= 1'b0;
      dout   <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= rd_ptr_nx;
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      // Head register reload: the next head is either already stored at
      // rd_ptr_nx, or is the word being pushed this very cycle.
      if (do_pop) begin
        if (count == CNT_W'(1)) begin
          valid <= do_push;
          if (do_push) dout <= din;
        end else begin
          valid <= 1'b1;
          dout  <= mem[rd_ptr_nx];
        end
      end else if ((count == '0) && do_push) begin
        valid <= 1'b1;
        dout  <= din;
      end
    end
  end

endmodule

// File: rtl/update_readback.sv
// update_readback
//   Walks a wrapping range of rule-RAM addresses, one read per cycle, and
//   returns the words on a valid/ready stream with a last marker. Reads are
//   only issued while in-flight reads plus buffered words stay below the FIFO
//   depth, so backpressure can never overflow the FIFO.
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   start, base_addr, len: scan request (sampled in IDLE only)
//   rd_en, rd_addr       : RAM read strobe/address
//   rd_data              : RAM data, valid RD_LAT cycles after rd_en
//   out_valid/data/last  : output stream; out_ready is the downstream accept
//   busy                 : scan in progress (READ or DRAIN)
//   done                 : one-cycle pulse after the last beat transfers
module update_readback
  import update_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   len,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  localparam int DEPTH = rb_depth(RD_LAT);
  localparam int CNT_W = rb_cnt_w(ADDR_W);
  localparam int OCC_W = $clog2(DEPTH + 1);

  rb_state_t         state;
  logic [CNT_W-1:0]  len_q;
  logic [CNT_W-1:0]  issued;
  logic              last_tag;
  logic [RD_LAT-1:0] vld_pipe;
  logic [RD_LAT-1:0] last_pipe;
  logic [OCC_W-1:0]  fifo_count;
  logic [OCC_W-1:0]  inflight;
  logic [OCC_W:0]    occupancy;
  logic [DATA_W:0]   fifo_dout;
  logic              beat;

  assign inflight  = OCC_W'($countones(vld_pipe));
  assign occupancy = {1'b0, inflight} + {1'b0, fifo_count};
  assign rd_en     = (state == READ) && (issued < len_q) &&
                     (occupancy < (OCC_W + 1)'(DEPTH));
  assign last_tag  = (issued == (len_q - 1'b1));
  assign beat      = out_valid && out_ready;
  assign busy      = (state == READ) || (state == DRAIN);
  assign done      = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      len_q   <= '0;
      issued  <= '0;
      rd_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            len_q   <= len;
            issued  <= '0;
            rd_addr <= base_addr;
            state   <= (len == '0) ? DONE : READ;
          end
        end
        READ: begin
          if (rd_en) begin
            issued  <= issued + 1'b1;
            rd_addr <= rd_addr + 1'b1;
            if (last_tag) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (beat && out_last) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // RAM latency stages: the valid bit matures in the cycle rd_data is valid
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[0] <= rd_en;
      for (int i = 1; i < RD_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  always_ff @(posedge clk) begin
    last_pipe[0] <= last_tag;
    for (int i = 1; i < RD_LAT; i++) last_pipe[i] <= last_pipe[i-1];
  end

  // Matured read enters the output FIFO with its last flag
  readback_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (vld_pipe[RD_LAT-1]),
    .din   ({last_pipe[RD_LAT-1], rd_data}),
    .pop   (out_ready),
    .dout  (fifo_dout),
    .valid (out_valid),
    .count (fifo_count)
  );

  assign out_last = fifo_dout[DATA_W];
  assign out_data = fifo_dout[DATA_W-1:0];

endmodule
